// File: rtl/sigdelta_pkg.sv
// Shared constants for the first-order sigma-delta ADC: FSM encoding and
// default geometry.
package sigdelta_pkg;

  localparam int DEF_SAMPLE_WIDTH = 8;
  localparam int DEF_SYNC_STAGES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/sigdelta_adc_sync_ff.sv
// Multi-flop synchronizer for the asynchronous comparator input.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sigdelta_adc.sv
// First-order sigma-delta ADC: comparator feedback loop plus a boxcar
// decimator producing one saturated sample per 2^SAMPLE_WIDTH cycles.
module sigdelta_adc
  import sigdelta_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    comp_in,
  output logic                    fb_out,
  output logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int W = SAMPLE_WIDTH;
  localparam logic [W-1:0] CNT_MAX = '1;

  state_t         state, state_nxt;
  logic [W-1:0]   cnt;
  logic [W:0]     acc, acc_sum;
  logic [W-1:0]   result;
  logic           comp_s;
  logic           active, win_end, new_res;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp_in),
    .q     (comp_s)
  );

  // Dropping enable aborts the window on the same edge it is seen.
  always_comb begin
    active  = (state != ST_IDLE) && enable;
    win_end = active && (cnt == CNT_MAX);
    acc_sum = acc + {{W{1'b0}}, comp_s};
    result  = acc_sum[W] ? CNT_MAX : acc_sum[W-1:0];
    new_res = win_end && (state == ST_RUN);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (enable) state_nxt = ST_SETTLE;
      ST_SETTLE: if (!enable) state_nxt = ST_IDLE;
                 else if (win_end) state_nxt = ST_RUN;
      ST_RUN:    if (!enable) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      acc          <= '0;
      fb_out       <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= active ? cnt + 1'b1 : '0;
      acc    <= (active && !win_end) ? acc_sum : '0;
      fb_out <= active ? comp_s : 1'b0;

      if (new_res) begin
        sample       <= result;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      // Setting beats clearing when both land on the same edge.
      if (new_res && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (overrun_clr)                         overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sigdelta_adc.sv
// Self-checking bench for sigdelta_adc (W=8): pattern table via scoreboard
// plus directed sequences for handshake, overrun, abort and reset.
module tb_sigdelta_adc;

  logic       clk = 1'b0;
  logic       rst_n, enable, comp_in, sample_ready, overrun_clr;
  logic       fb_out, sample_valid, overrun;
  logic [7:0] sample;

  int n_vec = 0;
  int n_bad = 0;
  int pat_p = 1;
  int pat_k = 0;
  int cyc   = 0;
  bit sb_on = 0;
  int exp_q[$];

  typedef struct { int p; int k; int exp_s; } vec_t;
  vec_t tbl[10];

  sigdelta_adc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .comp_in      (comp_in),
    .fb_out       (fb_out),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!sample_valid && n < bound) begin
      tick();
      n++;
    end
  endtask

  // Comparator stimulus: periodic pattern with k ones per p cycles.
  initial begin
    comp_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      comp_in = ((cyc % pat_p) < pat_k);
    end
  end

  // Scoreboard: compare each transferred sample against the queue head.
  always @(negedge clk) begin
    if (sb_on && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected: got sample %0d expected none", sample);
      end else begin
        chk("sb_sample", {24'd0, sample}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, hi;
    tbl[0] = '{1, 0, 0};
    tbl[1] = '{1, 1, 255};
    tbl[2] = '{2, 1, 128};
    tbl[3] = '{4, 1, 64};
    tbl[4] = '{4, 3, 192};
    tbl[5] = '{8, 5, 160};
    tbl[6] = '{256, 1, 1};
    tbl[7] = '{256, 100, 100};
    tbl[8] = '{256, 255, 255};
    tbl[9] = '{128, 127, 254};

    rst_n = 0; enable = 0; sample_ready = 0; overrun_clr = 0;
    repeat (3) tick();
    chk("rst_fb", fb_out, 0);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1;
    tick();

    // Latency and one-cycle valid pulses every window with ready held high.
    pat_p = 1; pat_k = 0; sample_ready = 1;
    enable = 1;
    wait_valid(700, n);
    chk("first_valid", sample_valid, 1);
    chk("first_latency", n, 513);
    chk("zero_sample", sample, 0);
    tick();
    chk("valid_pulse", sample_valid, 0);
    m = 1;
    while (!sample_valid && m < 400) begin tick(); m++; end
    chk("pulse_spacing", m, 256);

    // Overrun: two RUN results with ready low.
    enable = 0;
    tick(); tick();
    chk("drained", sample_valid, 0);
    sample_ready = 0;
    enable = 1;
    wait_valid(700, n);
    chk("ovr_first_valid", sample_valid, 1);
    chk("ovr_first_sample", sample, 0);
    pat_p = 1; pat_k = 1;
    repeat (255) tick();
    chk("hold_sample", sample, 0);
    chk("hold_overrun", overrun, 0);
    tick();
    chk("second_sample", sample, 254);
    chk("second_valid", sample_valid, 1);
    chk("overrun_set", overrun, 1);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    chk("overrun_clr", overrun, 0);
    repeat (254) tick();
    chk("pre_third_ovr", overrun, 0);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    chk("set_wins_clr", overrun, 1);
    chk("third_sample_sat", sample, 255);

    // Abort at RUN cycle 100: outputs retained, feedback released.
    repeat (100) tick();
    chk("fb_running", fb_out, 1);
    enable = 0;
    tick();
    chk("abort_fb", fb_out, 0);
    chk("abort_sample", sample, 255);
    chk("abort_valid", sample_valid, 1);
    chk("abort_overrun", overrun, 1);
    repeat (300) tick();
    chk("idle_sample", sample, 255);
    chk("idle_valid", sample_valid, 1);
    pat_p = 1; pat_k = 0;
    enable = 1;
    n = 0;
    while (sample == 8'd255 && n < 700) begin tick(); n++; end
    chk("reenable_latency", n, 513);
    chk("reenable_sample", sample, 0);

    // Synchronous reset mid-RUN with a pending sample.
    pat_p = 1; pat_k = 1;
    repeat (50) tick();
    chk("pre_rst_fb", fb_out, 1);
    chk("pre_rst_valid", sample_valid, 1);
    rst_n = 0;
    tick();
    chk("mid_rst_fb", fb_out, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_sample", sample, 0);
    rst_n = 1;
    hi = 0;
    repeat (500) begin tick(); if (sample_valid) hi++; end
    chk("no_sample_after_rst", hi, 0);

    // Pattern table through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      enable = 0;
      sample_ready = 1;
      pat_p = tbl[i].p;
      pat_k = tbl[i].k;
      repeat (3) tick();
      exp_q.push_back(tbl[i].exp_s);
      sb_on = 1;
      enable = 1;
      n = 0;
      while (exp_q.size() != 0 && n < 700) begin tick(); n++; end
      if (exp_q.size() != 0) begin
        chk("sb_timeout", exp_q.size(), 0);
        exp_q.delete();
      end
      if (tbl[i].p == 1) chk("fb_const", fb_out, tbl[i].k);
      enable = 0;
      tick();
      sb_on = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sigdelta_adc.md
SIGDELTA_ADC -- requirements
Module: sigdelta_adc

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 8, giving output sample bits; the decimation window is 2^SAMPLE_WIDTH enabled cycles.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the number of comparator synchronizer flops (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port enable, input, 1 bit: converter run request.
REQ-006 SHALL have port comp_in, input, 1 bit: asynchronous external comparator output (input voltage above RC integrator voltage).
REQ-007 SHALL have port fb_out, output, 1 bit: 1-bit feedback driving the external RC integrator.
REQ-008 SHALL have port sample, output, SAMPLE_WIDTH bits: the decimated unsigned sample.
REQ-009 SHALL have port sample_valid, output, 1 bit: sample holds an unconsumed result.
REQ-010 SHALL have port sample_ready, input, 1 bit: consumer accepts the sample.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, an unconsumed sample was overwritten.
REQ-012 SHALL have port overrun_clr, input, 1 bit: clears overrun.

Function
REQ-013 comp_in SHALL pass through SYNC_STAGES flops; the last stage is comp_s.
REQ-014 fb_out SHALL be registered: fb_out <= comp_s in SETTLE/RUN, 0 in IDLE.
REQ-015 FSM states SHALL be IDLE, SETTLE, RUN; IDLE->SETTLE when enable=1; SETTLE->RUN at the window end; any state->IDLE when enable=0.
REQ-016 The window counter (SAMPLE_WIDTH bits) SHALL increment each SETTLE/RUN cycle, wrap 2^W-1->0, and be held at 0 in IDLE.
REQ-017 The accumulator (SAMPLE_WIDTH+1 bits) SHALL add comp_s each SETTLE/RUN cycle, clear at the window end, and be held at 0 in IDLE.
REQ-018 At the window end (counter = 2^W-1), the result SHALL be acc+comp_s, saturated to 2^W-1 when it equals 2^W.
REQ-019 SETTLE window results SHALL be discarded; RUN window results SHALL load sample, with sample_valid=1 on the next cycle (latency 1).
REQ-020 Handshake: a transfer SHALL occur on an edge with sample_valid=1 and sample_ready=1; after a transfer with no new result, sample_valid SHALL go to 0.
REQ-021 sample SHALL be stable while sample_valid=1 and no new result loads.
REQ-022 A new result while sample_valid=1 and sample_ready=0 SHALL overwrite sample, keep sample_valid=1, and set overrun.
REQ-023 A new result on a transfer edge SHALL load sample, keep sample_valid=1, and leave overrun unchanged.
REQ-024 On the same edge, overrun set SHALL win over overrun_clr.
REQ-025 Deasserting enable SHALL abort the partial window with no result, and SHALL retain sample, sample_valid and overrun.
REQ-026 Re-enable SHALL always restart with a SETTLE window.

Reset
REQ-027 With rst_n=0 at an edge: state=IDLE, counter=0, acc=0, synchronizer=0, fb_out=0, sample=0, sample_valid=0, overrun=0.
REQ-028 Reset mid-window SHALL discard all partial results with no sample emitted.

Structure
REQ-029 Package sigdelta_pkg SHALL hold the FSM state encoding constants and the default SAMPLE_WIDTH/SYNC_STAGES values.
REQ-030 The synchronizer SHALL be sub-module sync_ff (parameter STAGES); all other logic SHALL be in sigdelta_adc.

Verification (W=8, window 256)
REQ-031 comp_in=1, enable=1, ready=1 -> first sample_valid 513 cycles after SETTLE entry (+sync latency), sample=255 (saturated), fb_out=1.
REQ-032 comp_in=0 -> sample=0 each window, sample_valid pulses one cycle per 256.
REQ-033 comp_s alternating 1/0 each cycle -> sample=128.
REQ-034 ready=0 over two RUN windows -> sample_valid held, overrun=1 after the 2nd result, sample=2nd value; pulse overrun_clr -> overrun=0.
REQ-035 Drop enable at RUN cycle 100 -> no new sample, fb_out=0 next cycle, prior sample/valid retained; re-enable -> full SETTLE window before the next result.
REQ-036 rst_n=0 mid-RUN with valid pending -> all outputs 0 next cycle; new-result overrun set with overrun_clr on the same edge -> overrun=1.
